id_ex_stage: RTL

Decode-to-execute pipeline register for the 64-bit RISC-V datapath, sitting directly upstream of the 64-bit ALU. Latches decoded operands and control under a valid/ready handshake with stall and flush. Generates the 4-bit ALU control code. Drives the ALU in1/in2/alu_control inputs from registered state.

---
 rtl/riscv_ex_pkg.sv | 31 +++
 rtl/alu_ctrl_dec.sv | 35 +++
 rtl/id_ex_stage.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/riscv_ex_pkg.sv
// Shared encodings for the ID/EX stage: ALU control codes, alu_op classes,
// funct3 values and id_ctrl bit positions.
package riscv_ex_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0100,
    ALU_SLT = 4'b1000
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ALUOP_LS  = 2'b00,
    ALUOP_BR  = 2'b01,
    ALUOP_R   = 2'b10,
    ALUOP_I   = 2'b11
  } alu_op_e;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam int CTRL_W          = 4;
  localparam int CTRL_REG_WRITE  = 3;
  localparam int CTRL_MEM_READ   = 2;
  localparam int CTRL_MEM_WRITE  = 1;
  localparam int CTRL_MEM_TO_REG = 0;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational decode of alu_op/funct3/funct7_5 into the 4-bit ALU control
// code, flagging funct3 values the ALU does not implement.
module alu_ctrl_dec
  import riscv_ex_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output logic [3:0] alu_control_o,
  output logic       illegal_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    illegal_o     = 1'b0;
    case (alu_op_i)
      ALUOP_LS: alu_control_o = ALU_ADD;
      ALUOP_BR: alu_control_o = ALU_SUB;
      default: begin
        case (funct3_i)
          // ADDI has no SUB form, so bit 30 only matters for R-type
          F3_ADD:  alu_control_o = (alu_op_i == ALUOP_R && funct7_5_i) ? ALU_SUB : ALU_ADD;
          F3_AND:  alu_control_o = ALU_AND;
          F3_OR:   alu_control_o = ALU_OR;
          F3_SLT:  alu_control_o = ALU_SLT;
          default: begin
            alu_control_o = ALU_ADD;
            illegal_o     = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the 64-bit ALU; valid/ready handshake with
// stall and flush. Define FWD_EN to add EX/MEM and MEM/WB operand forwarding.
module id_ex_stage
  import riscv_ex_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [1:0]        id_alu_op,
  input  logic [2:0]        id_funct3,
  input  logic              id_funct7_5,
  input  logic              id_alu_src,
  input  logic [CTRL_W-1:0] id_ctrl,
`ifdef FWD_EN
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic              exm_reg_write,
  input  logic [XLEN-1:0]   exm_result,
  input  logic [REG_AW-1:0] mwb_rd,
  input  logic              mwb_reg_write,
  input  logic [XLEN-1:0]   mwb_result,
`endif
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [XLEN-1:0]   ex_in1,
  output logic [XLEN-1:0]   ex_in2,
  output logic [3:0]        ex_alu_control,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [XLEN-1:0]   ex_pc,
  output logic [REG_AW-1:0] ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_illegal
);

  logic [3:0]        dec_code;
  logic              dec_ill;

  logic              vld_q, vld_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              load;
  logic [XLEN-1:0]   pc_q, rs1d_q, rs2d_q, imm_q;
  logic [REG_AW-1:0] rd_q;
  logic [3:0]        code_q;
  logic              ill_q, src_q;
  logic [XLEN-1:0]   rs1_val, rs2_val;

  alu_ctrl_dec u_dec (
    .alu_op_i      (id_alu_op),
    .funct3_i      (id_funct3),
    .funct7_5_i    (id_funct7_5),
    .alu_control_o (dec_code),
    .illegal_o     (dec_ill)
  );

  assign id_ready = !vld_q || ex_ready;
  assign load     = !flush && id_ready && id_valid;

  // Flush and bubbles clear valid and ctrl only; the rest of the payload holds.
  always_comb begin
    vld_d  = vld_q;
    ctrl_d = ctrl_q;
    if (flush) begin
      vld_d  = 1'b0;
      ctrl_d = '0;
    end else if (id_ready) begin
      vld_d  = id_valid;
      ctrl_d = id_valid ? id_ctrl : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      ctrl_q <= '0;
    end else begin
      vld_q  <= vld_d;
      ctrl_q <= ctrl_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= '0;
      rs1d_q <= '0;
      rs2d_q <= '0;
      imm_q  <= '0;
      rd_q   <= '0;
      code_q <= '0;
      ill_q  <= 1'b0;
      src_q  <= 1'b0;
    end else if (load) begin
      pc_q   <= id_pc;
      rs1d_q <= id_rs1_data;
      rs2d_q <= id_rs2_data;
      imm_q  <= id_imm;
      rd_q   <= id_rd;
      code_q <= dec_code;
      ill_q  <= dec_ill;
      src_q  <= id_alu_src;
    end
  end

`ifdef FWD_EN
  logic [REG_AW-1:0] rs1a_q, rs2a_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1a_q <= '0;
      rs2a_q <= '0;
    end else if (load) begin
      rs1a_q <= id_rs1;
      rs2a_q <= id_rs2;
    end
  end

  // x0 is never forwarded; the younger EX/MEM result wins over MEM/WB.
  function automatic logic [XLEN-1:0] fwd(input logic [REG_AW-1:0] src,
                                          input logic [XLEN-1:0]   regval);
    if (exm_reg_write && exm_rd != '0 && exm_rd == src)      return exm_result;
    else if (mwb_reg_write && mwb_rd != '0 && mwb_rd == src) return mwb_result;
    else                                                     return regval;
  endfunction

  assign rs1_val = fwd(rs1a_q, rs1d_q);
  assign rs2_val = fwd(rs2a_q, rs2d_q);
`else
  assign rs1_val = rs1d_q;
  assign rs2_val = rs2d_q;
`endif

  assign ex_valid       = vld_q;
  assign ex_ctrl        = ctrl_q;
  assign ex_in1         = rs1_val;
  assign ex_in2         = src_q ? imm_q : rs2_val;
  assign ex_store_data  = rs2_val;
  assign ex_alu_control = code_q;
  assign ex_pc          = pc_q;
  assign ex_rd          = rd_q;
  assign ex_illegal     = ill_q;

endmodule
